// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, port-grant encoding and small helpers
// for the framebuffer port arbiter slice.
package fb_pkg;

  localparam int FB_ADDR_W  = 19;
  localparam int FB_DATA_W  = 4;
  localparam int FB_H_WORDS = 160;
  localparam int FB_V_LINES = 240;
  localparam int FB_WORDS   = FB_H_WORDS * FB_V_LINES;

  typedef enum logic [1:0] {
    G_IDLE,
    G_READ,
    G_WRITE
  } grant_e;

  // Drop counter must stick at all-ones rather than wrap back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous show-ahead FIFO holding pending capture writes as {addr,data};
// the head entry is visible on o_addr/o_data whenever o_empty is low.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [ADDR_W-1:0]        o_addr,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign {o_addr, o_data} = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= {i_addr, i_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares the single-port framebuffer BRAM between buffered capture writes and
// scan-out reads; reads win unless the write FIFO is nearly full or starved.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int WF_DEPTH     = 16,
  parameter int HIGH_WATER   = 12,
  parameter int MAX_RD_BURST = 32
) (
  input  logic              lcd_clk,
  input  logic              rst,
  input  logic              wr_we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              wr_overflow,
  output logic [15:0]       drop_count
);

  localparam int CNT_W   = $clog2(WF_DEPTH) + 1;
  localparam int BURST_W = $clog2(MAX_RD_BURST + 1);

  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [DATA_W-1:0]  w_head_data;
  logic               w_fifo_push;
  logic               w_fifo_pop;
  logic               w_drop;
  logic               w_force_wr;
  grant_e             w_grant;

  logic [BURST_W-1:0] r_burst_cnt;
  logic [ADDR_W-1:0]  r_ram_addr;
  logic               r_ram_we;
  logic [DATA_W-1:0]  r_ram_wdata;
  logic               r_rd_pipe;
  logic               r_rd_valid;
  logic               r_wr_overflow;
  logic [15:0]        r_drop_count;

  fb_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WF_DEPTH)
  ) u_wr_fifo (
    .i_clk   (lcd_clk),
    .i_rst   (rst),
    .i_push  (w_fifo_push),
    .i_addr  (wr_addr),
    .i_data  (wr_data),
    .i_pop   (w_fifo_pop),
    .o_addr  (w_head_addr),
    .o_data  (w_head_data),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // A write slot is forced before the FIFO can fill, or when a long read
  // burst has kept a pending write waiting too long.
  assign w_force_wr = (int'(w_fifo_count) >= HIGH_WATER) ||
                      ((int'(r_burst_cnt) >= MAX_RD_BURST) && !w_fifo_empty);
  assign rd_ready   = !w_force_wr;

  always_comb begin
    w_grant = G_IDLE;
    if (!rst) begin
      if (rd_req && rd_ready) begin
        w_grant = G_READ;
      end else if (!w_fifo_empty) begin
        w_grant = G_WRITE;
      end
    end
  end

  assign w_fifo_push = wr_we && !rst;
  assign w_fifo_pop  = (w_grant == G_WRITE);
  assign w_drop      = w_fifo_push && w_fifo_full && !w_fifo_pop;

  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
    end else begin
      case (w_grant)
        G_READ: begin
          r_ram_addr <= rd_addr;
          r_ram_we   <= 1'b0;
        end
        G_WRITE: begin
          r_ram_addr  <= w_head_addr;
          r_ram_wdata <= w_head_data;
          r_ram_we    <= 1'b1;
        end
        default: begin
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage valid pipe matches address register plus BRAM output latency.
  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      r_rd_pipe  <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_pipe  <= (w_grant == G_READ);
      r_rd_valid <= r_rd_pipe;
    end
  end

  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      r_burst_cnt <= '0;
    end else if ((w_grant == G_WRITE) || w_fifo_empty) begin
      r_burst_cnt <= '0;
    end else if ((w_grant == G_READ) && (int'(r_burst_cnt) < MAX_RD_BURST)) begin
      r_burst_cnt <= r_burst_cnt + BURST_W'(1);
    end
  end

  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      r_wr_overflow <= 1'b0;
      r_drop_count  <= '0;
    end else if (w_drop) begin
      r_wr_overflow <= 1'b1;
      r_drop_count  <= sat_inc16(r_drop_count);
    end
  end

  assign ram_addr    = r_ram_addr;
  assign ram_we      = r_ram_we;
  assign ram_wdata   = r_ram_wdata;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_valid ? ram_rdata : '0;
  assign wr_overflow = r_wr_overflow;
  assign drop_count  = r_drop_count;

endmodule
